// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, display letter codes and FSM state shared by the ALU slice.
package alu_pkg;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_NOT = 3;
    localparam int OP_AND = 4;
    localparam int OP_OR  = 5;
    localparam int OP_XOR = 6;
    localparam int OP_SHL = 7;
    localparam int OP_SHR = 8;
    localparam int OP_MUL = 9;
    typedef logic [3:0] disp_t;
    localparam disp_t DISP_NONE = 4'h0;
    localparam disp_t DISP_A    = 4'hA;
    localparam disp_t DISP_B    = 4'hB;
    localparam disp_t DISP_RES  = 4'hC;
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: switch/command inputs and result/flag/display outputs of the ALU.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw;
    logic             load_a;
    logic             load_b;
    logic             exec;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] mul_hi;
    logic             ovf;
    logic             busy;
    logic             done;
    disp_t            disp_sel;
    modport master (
        output sw, load_a, load_b, exec,
        input  result, carry, zero, mul_hi, ovf, busy, done, disp_sel
    );
    modport slave (
        input  sw, load_a, load_b, exec,
        output result, carry, zero, mul_hi, ovf, busy, done, disp_sel
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one step per cycle, WIDTH steps.
// done is high on the cycle whose clock edge performs the final step; product is that step's result.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    // lo starts as the multiplier and is shifted out as product bits shift in
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        product = {sum, lo[WIDTH-1:1]};
        done    = busy && cnt == CW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH);
            mcand <= a;
            hi    <= '0;
            lo    <= b;
        end else if (busy) begin
            {hi, lo} <= product;
            cnt      <= cnt - CW'(1);
            busy     <= cnt != CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: synchronous ALU with operands latched from the switch bus and a multi-cycle MUL.
// Define ALU_OVF_FLAG_EN to drive ovf with signed overflow for ADD/SUB; otherwise ovf stays 0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int M = WIDTH - 1;
    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [OPW-1:0]     op;
    logic [WIDTH:0]     wide;
    logic               alu_v;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    assign op        = bus.sw[OPW-1:0];
    assign mul_start = state == ST_IDLE && !bus.load_a && !bus.load_b && bus.exec && op == OPW'(OP_MUL);
    assign bus.busy  = mul_busy;
    // wide carries the carry/borrow/shifted-out bit in its top position
    always_comb begin
        wide = '0;
        case (op)
            OPW'(OP_ADD): wide = {1'b0, a_q} + {1'b0, b_q};
            OPW'(OP_SUB): wide = {1'b0, a_q} - {1'b0, b_q};
            OPW'(OP_NOT): wide = {1'b0, ~a_q};
            OPW'(OP_AND): wide = {1'b0, a_q & b_q};
            OPW'(OP_OR):  wide = {1'b0, a_q | b_q};
            OPW'(OP_XOR): wide = {1'b0, a_q ^ b_q};
            OPW'(OP_SHL): wide = {a_q, 1'b0};
            OPW'(OP_SHR): wide = {a_q[0], 1'b0, a_q[M:1]};
            default:      wide = '0;
        endcase
`ifdef ALU_OVF_FLAG_EN
        alu_v = op == OPW'(OP_ADD) ? (a_q[M] == b_q[M]) && (wide[M] != a_q[M]) :
                op == OPW'(OP_SUB) ? (a_q[M] != b_q[M]) && (wide[M] != a_q[M]) : 1'b0;
`else
        alu_v = 1'b0;
`endif
    end
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            bus.result   <= '0;
            bus.carry    <= 1'b0;
            bus.zero     <= 1'b0;
            bus.mul_hi   <= '0;
            bus.ovf      <= 1'b0;
            bus.done     <= 1'b0;
            bus.disp_sel <= DISP_NONE;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.load_a || bus.load_b) begin
                        a_q          <= bus.load_a ? bus.sw : a_q;
                        b_q          <= bus.load_a ? b_q : bus.sw;
                        bus.result   <= bus.sw;
                        bus.carry    <= 1'b0;
                        bus.zero     <= bus.sw == '0;
                        bus.ovf      <= 1'b0;
                        bus.disp_sel <= bus.load_a ? DISP_A : DISP_B;
                    end else if (mul_start) begin
                        state <= ST_MUL;
                    end else if (bus.exec) begin
                        bus.result   <= wide[M:0];
                        bus.carry    <= wide[WIDTH];
                        bus.zero     <= wide[M:0] == '0;
                        bus.ovf      <= alu_v;
                        bus.disp_sel <= DISP_RES;
                        bus.done     <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state        <= ST_IDLE;
                        bus.mul_hi   <= product[2*WIDTH-1:WIDTH];
                        bus.result   <= product[M:0];
                        bus.carry    <= product[2*WIDTH-1:WIDTH] != '0;
                        bus.zero     <= product[M:0] == '0;
                        bus.ovf      <= 1'b0;
                        bus.disp_sel <= DISP_RES;
                        bus.done     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for the 8-bit alu_seq.
module tb_alu_seq;
    localparam bit OVF_EN =
`ifdef ALU_OVF_FLAG_EN
        1'b1;
`else
        1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    alu_seq_if #(.WIDTH(8)) bus ();
    alu_seq #(.WIDTH(8), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic pulse(input logic la, input logic lb, input logic ex, input logic [7:0] v);
        @(negedge clk);
        bus.sw = v; bus.load_a = la; bus.load_b = lb; bus.exec = ex;
        @(negedge clk);
        bus.load_a = 1'b0; bus.load_b = 1'b0; bus.exec = 1'b0;
    endtask

    task automatic test_reset();
        bus.sw = 8'h00; bus.load_a = 1'b0; bus.load_b = 1'b0; bus.exec = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", bus.result); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
        n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
        n_checks++; if (bus.mul_hi !== 8'h00) begin n_fail++; $display("FAIL reset_mul_hi: got %h want 00", bus.mul_hi); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.disp_sel !== 4'h0) begin n_fail++; $display("FAIL reset_disp: got %h want 0", bus.disp_sel); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        pulse(1'b1, 1'b0, 1'b0, 8'h05);
        n_checks++; if (bus.result !== 8'h05) begin n_fail++; $display("FAIL load_a_result: got %h want 05", bus.result); end
        n_checks++; if (bus.disp_sel !== 4'hA) begin n_fail++; $display("FAIL load_a_disp: got %h want A", bus.disp_sel); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL load_a_done: got %b want 0", bus.done); end
        pulse(1'b0, 1'b1, 1'b0, 8'h03);
        n_checks++; if (bus.disp_sel !== 4'hB) begin n_fail++; $display("FAIL load_b_disp: got %h want B", bus.disp_sel); end
        pulse(1'b0, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'h08) begin n_fail++; $display("FAIL add_result: got %h want 08", bus.result); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL add_carry: got %b want 0", bus.carry); end
        n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", bus.zero); end
        n_checks++; if (bus.disp_sel !== 4'hC) begin n_fail++; $display("FAIL add_disp: got %h want C", bus.disp_sel); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", bus.done); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL add_done_single: got %b want 0", bus.done); end
    endtask

    task automatic test_add_carry();
        pulse(1'b1, 1'b0, 1'b0, 8'hFF);
        pulse(1'b0, 1'b1, 1'b0, 8'h01);
        pulse(1'b0, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL addc_result: got %h want 00", bus.result); end
        n_checks++; if (bus.carry !== 1'b1) begin n_fail++; $display("FAIL addc_carry: got %b want 1", bus.carry); end
        n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL addc_zero: got %b want 1", bus.zero); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL addc_ovf: got %b want 0", bus.ovf); end
        pulse(1'b1, 1'b0, 1'b0, 8'h7F);
        pulse(1'b0, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'h80) begin n_fail++; $display("FAIL addv_result: got %h want 80", bus.result); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL addv_carry: got %b want 0", bus.carry); end
        n_checks++; if (bus.ovf !== OVF_EN) begin n_fail++; $display("FAIL addv_ovf: got %b want %b", bus.ovf, OVF_EN); end
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL load_ovf_clear: got %b want 0", bus.ovf); end
        n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL load_zero: got %b want 1", bus.zero); end
    endtask

    task automatic test_logic_shift();
        pulse(1'b1, 1'b0, 1'b0, 8'h03);
        pulse(1'b0, 1'b1, 1'b0, 8'h05);
        pulse(1'b0, 1'b0, 1'b1, 8'h02);
        n_checks++; if (bus.result !== 8'hFE) begin n_fail++; $display("FAIL sub_result: got %h want FE", bus.result); end
        n_checks++; if (bus.carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow: got %b want 1", bus.carry); end
        pulse(1'b0, 1'b0, 1'b1, 8'h08);
        n_checks++; if (bus.result !== 8'h01) begin n_fail++; $display("FAIL shr_result: got %h want 01", bus.result); end
        n_checks++; if (bus.carry !== 1'b1) begin n_fail++; $display("FAIL shr_carry: got %b want 1", bus.carry); end
        pulse(1'b0, 1'b0, 1'b1, 8'h07);
        n_checks++; if (bus.result !== 8'h06) begin n_fail++; $display("FAIL shl_result: got %h want 06", bus.result); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL shl_carry: got %b want 0", bus.carry); end
        pulse(1'b0, 1'b0, 1'b1, 8'h03);
        n_checks++; if (bus.result !== 8'hFC) begin n_fail++; $display("FAIL not_result: got %h want FC", bus.result); end
        pulse(1'b0, 1'b0, 1'b1, 8'h04);
        n_checks++; if (bus.result !== 8'h01) begin n_fail++; $display("FAIL and_result: got %h want 01", bus.result); end
        pulse(1'b0, 1'b0, 1'b1, 8'h05);
        n_checks++; if (bus.result !== 8'h07) begin n_fail++; $display("FAIL or_result: got %h want 07", bus.result); end
        pulse(1'b0, 1'b0, 1'b1, 8'h06);
        n_checks++; if (bus.result !== 8'h06) begin n_fail++; $display("FAIL xor_result: got %h want 06", bus.result); end
        pulse(1'b1, 1'b0, 1'b0, 8'h81);
        pulse(1'b0, 1'b0, 1'b1, 8'h07);
        n_checks++; if (bus.result !== 8'h02) begin n_fail++; $display("FAIL shl_msb_result: got %h want 02", bus.result); end
        n_checks++; if (bus.carry !== 1'b1) begin n_fail++; $display("FAIL shl_msb_carry: got %b want 1", bus.carry); end
        pulse(1'b0, 1'b0, 1'b1, 8'h0E);
        n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL badop_result: got %h want 00", bus.result); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL badop_carry: got %b want 0", bus.carry); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL badop_done: got %b want 1", bus.done); end
    endtask

    task automatic test_mul();
        int cyc;
        pulse(1'b1, 1'b0, 1'b0, 8'h0F);
        pulse(1'b0, 1'b1, 1'b0, 8'h11);
        pulse(1'b0, 1'b0, 1'b1, 8'h09);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 20) begin
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_early: got %b want 0 at busy %0d", bus.done, cyc); end
            cyc++;
            @(negedge clk);
        end
        n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 8", cyc); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL mul_done: got %b want 1", bus.done); end
        n_checks++; if (bus.result !== 8'hFF) begin n_fail++; $display("FAIL mul_lo: got %h want FF", bus.result); end
        n_checks++; if (bus.mul_hi !== 8'h00) begin n_fail++; $display("FAIL mul_hi: got %h want 00", bus.mul_hi); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL mul_carry: got %b want 0", bus.carry); end
        n_checks++; if (bus.disp_sel !== 4'hC) begin n_fail++; $display("FAIL mul_disp: got %h want C", bus.disp_sel); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_single: got %b want 0", bus.done); end
    endtask

    task automatic test_busy_lockout();
        int cyc;
        pulse(1'b1, 1'b0, 1'b0, 8'hFF);
        pulse(1'b0, 1'b1, 1'b0, 8'hFF);
        pulse(1'b0, 1'b0, 1'b1, 8'h09);
        pulse(1'b1, 1'b0, 1'b0, 8'h22);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL mulff_done: got %b want 1", bus.done); end
        n_checks++; if (bus.result !== 8'h01) begin n_fail++; $display("FAIL mulff_lo: got %h want 01", bus.result); end
        n_checks++; if (bus.mul_hi !== 8'hFE) begin n_fail++; $display("FAIL mulff_hi: got %h want FE", bus.mul_hi); end
        n_checks++; if (bus.carry !== 1'b1) begin n_fail++; $display("FAIL mulff_carry: got %b want 1", bus.carry); end
        pulse(1'b0, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'hFE) begin n_fail++; $display("FAIL busy_hold_a: got %h want FE", bus.result); end
        n_checks++; if (bus.mul_hi !== 8'hFE) begin n_fail++; $display("FAIL mul_hi_hold: got %h want FE", bus.mul_hi); end
    endtask

    task automatic test_priority();
        pulse(1'b1, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'h01) begin n_fail++; $display("FAIL prio_a_result: got %h want 01", bus.result); end
        n_checks++; if (bus.disp_sel !== 4'hA) begin n_fail++; $display("FAIL prio_a_disp: got %h want A", bus.disp_sel); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL prio_a_done: got %b want 0", bus.done); end
        pulse(1'b0, 1'b1, 1'b1, 8'h02);
        n_checks++; if (bus.disp_sel !== 4'hB) begin n_fail++; $display("FAIL prio_b_disp: got %h want B", bus.disp_sel); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL prio_b_done: got %b want 0", bus.done); end
        pulse(1'b0, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'h03) begin n_fail++; $display("FAIL prio_add: got %h want 03", bus.result); end
    endtask

    task automatic test_reset_mid_mul();
        pulse(1'b0, 1'b0, 1'b1, 8'h09);
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL midrst_result: got %h want 00", bus.result); end
        n_checks++; if (bus.mul_hi !== 8'h00) begin n_fail++; $display("FAIL midrst_mul_hi: got %h want 00", bus.mul_hi); end
        n_checks++; if (bus.disp_sel !== 4'h0) begin n_fail++; $display("FAIL midrst_disp: got %h want 0", bus.disp_sel); end
        n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL midrst_zero: got %b want 0", bus.zero); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: done %b busy %b want 0 0 at %0d", bus.done, bus.busy, i); end
            @(negedge clk);
        end
        pulse(1'b0, 1'b0, 1'b1, 8'h0F);
        n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL post_rst_result: got %h want 00", bus.result); end
        n_checks++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL post_rst_carry: got %b want 0", bus.carry); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL post_rst_done: got %b want 1", bus.done); end
        n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL post_rst_zero: got %b want 1", bus.zero); end
        pulse(1'b0, 1'b0, 1'b1, 8'h01);
        n_checks++; if (bus.result !== 8'h00 || bus.carry !== 1'b0) begin n_fail++; $display("FAIL post_rst_ab: got %h/%b want 00/0", bus.result, bus.carry); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_carry();
        test_logic_shift();
        test_mul();
        test_busy_lockout();
        test_priority();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, fully synchronous successor of the board-level 8-bit ALU.
- Operand A and operand B are captured from the switch bus on single-cycle command pulses. The opcode is taken from the switch bus on an execute pulse.
- Single-cycle logic/arithmetic ops are supported, plus a multi-cycle shift-add multiply with busy/done handshake.
- Sits between the debounce/edge-detect front end and the LED/7-segment display driver.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).
- OPW, 4, opcode field width, taken from sw[OPW-1:0] (OPW <= WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  WIDTH  switch bus; operand data or opcode.
- load_a  in  1  one-cycle pulse: capture sw into A.
- load_b  in  1  one-cycle pulse: capture sw into B.
- exec  in  1  one-cycle pulse: start op sw[OPW-1:0].
- result  out  WIDTH  registered result / displayed value.
- carry  out  1  carry/borrow/shifted-out bit.
- zero  out  1  result == 0 (registered with result).
- mul_hi  out  WIDTH  upper half of last MUL product.
- ovf  out  1  signed overflow (see Optional Feature).
- busy  out  1  high while MUL iterates.
- done  out  1  one-cycle pulse when result is updated by exec.
- disp_sel  out  4  display letter code: 0x0 none, 0xA A, 0xB B, 0xC result.

Behaviour:
- Reset values: all outputs 0; internal A=0, B=0; FSM=IDLE.
- rst has absolute priority, including mid-MUL, which is aborted with no done pulse.
- Command priority in IDLE: load_a > load_b > exec. Lower-priority commands in the same cycle are dropped.
- While busy: load_a, load_b and exec are ignored; A and B are held.
- load_a at edge k:
  - A<=sw, result<=sw, carry<=0, zero<=(sw==0), disp_sel<=0xA.
  - No done pulse.
- load_b: same as load_a, with B and disp_sel<=0xB.
- exec, single-cycle ops: result, carry, zero and disp_sel<=0xC all update at the edge sampling exec. done=1 during the following cycle only.
- Opcodes:
  - 1 ADD: {carry,result}=A+B, WIDTH+1 bits.
  - 2 SUB: {carry,result}=A-B; carry=1 means borrow (A<B).
  - 3 NOT: ~A, carry=0.
  - 4 AND, 5 OR, 6 XOR: carry=0.
  - 7 SHL: result=A<<1, carry=A[WIDTH-1].
  - 8 SHR: logical, result=A>>1, carry=A[0].
  - 9 MUL: unsigned A*B, multi-cycle.
  - Any other code: result=0, carry=0, still pulses done.
- FSM IDLE -> MUL -> IDLE:
  - exec with op 9 moves to MUL and loads an iteration counter with WIDTH.
  - busy=1 for exactly WIDTH cycles; one shift-add step per cycle.
  - On the final step: {mul_hi,result}<=product, carry<=(product[2*WIDTH-1:WIDTH]!=0), zero<=(low half==0), disp_sel<=0xC.
  - done pulses in the cycle after the last busy cycle. Total exec-to-done latency is WIDTH+1 cycles.
- mul_hi changes only on MUL completion or reset.
- Widths: all arithmetic is unsigned, truncated to WIDTH, with overflow indicated via carry.

Optional Feature:
- ALU_OVF_FLAG_EN defined:
  - ovf = two's-complement overflow for ADD/SUB, updated with result.
  - ovf=0 for all other ops and for loads.
- ALU_OVF_FLAG_EN undefined: ovf is tied to 0; port is still present.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD..OP_MUL;
  - display codes DISP_NONE/DISP_A/DISP_B/DISP_RES;
  - FSM state typedef.
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/busy/done, parametrised by WIDTH.

Test Plan:
- Reset then load_a sw=0x05, load_b sw=0x03, exec sw=0x01 -> result=0x08, carry=0, zero=0, disp_sel=0xC, one done pulse.
- A=0xFF, B=0x01, exec ADD -> result=0x00, carry=1, zero=1. With ALU_OVF_FLAG_EN: A=0x7F, B=0x01 ADD -> ovf=1.
- A=0x03, B=0x05, exec SUB -> result=0xFE, carry=1. exec SHR on A=0x03 -> result=0x01, carry=1.
- A=0x0F, B=0x11, exec MUL -> busy high 8 cycles, done at cycle 9, {mul_hi,result}=0x00FF, carry=0. A=0xFF, B=0xFF -> 0xFE01, carry=1.
- load_a pulsed during MUL busy -> A unchanged. Same-cycle load_a+exec in IDLE -> only A loaded, no done.
- rst asserted mid-MUL at busy cycle 4 -> next cycle all outputs 0, busy=0, no done. exec sw=0x0F -> result=0, carry=0, done=1.
